// File: rtl/seg7_display_mux.sv
// Multiplexed 7-segment driver: hex or binary-to-BCD (double-dabble) display
// register, leading-zero blanking, decimal points and a fixed-rate digit scan.
module seg7_display_mux #(
  parameter  int NUM_DIGITS  = 8,
  parameter  int REFRESH_DIV = 100000,
  localparam int W           = 4 * NUM_DIGITS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  load,
  input  logic [W-1:0]          data_in,
  input  logic                  mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            out7,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] en_out,
  output logic                  state_dbg
);

  localparam int IW = $clog2(W + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int XW = $clog2(NUM_DIGITS);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  // Handshake: load is a one-cycle strobe, accepted only on an edge where
  // busy is low; a strobe seen while busy is high is dropped without effect.
  state_t                state;
  logic [W-1:0]          bin_q, bcd_q, disp_q;
  logic [NUM_DIGITS-1:0] dp_q, dp_pend_q;
  logic                  ovf_acc_q;
  logic [IW-1:0]         iter_q;
  logic [RW-1:0]         refresh_q;
  logic [XW-1:0]         idx_q;

  logic [W-1:0]          bcd_adj, bcd_next, bin_next;
  logic                  carry;
  logic [NUM_DIGITS-1:0] lz;
  logic                  above, blank;
  logic [3:0]            digit;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] en_next;

  assign busy      = (state == CONV);
  assign state_dbg = state;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // One double-dabble step; the carry out of the top digit is a multiple of
  // 10^NUM_DIGITS, so dropping it leaves value mod 10^NUM_DIGITS.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    {carry, bcd_next} = {bcd_adj, bin_q[W-1]};
    bin_next = {bin_q[W-2:0], 1'b0};
  end

  always_comb begin
    lz    = '0;
    above = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      above = above && (disp_q[4*d +: 4] == 4'd0);
      lz[d] = above;
    end
    digit    = disp_q[{idx_q, 2'b00} +: 4];
    blank    = blank_lz && (idx_q != '0) && !dp_q[idx_q] && lz[idx_q];
    seg_next = blank ? 7'h7F : hex7(digit);
    dp_next  = blank ? 1'b1 : ~dp_q[idx_q];
    en_next  = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
      dp_q      <= '0;
      dp_pend_q <= '0;
      ovf_acc_q <= 1'b0;
      ovf       <= 1'b0;
      iter_q    <= '0;
      refresh_q <= '0;
      idx_q     <= '0;
      out7      <= 7'h7F;
      dp_out    <= 1'b1;
      en_out    <= '1;
    end else begin
      if (refresh_q == RW'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        idx_q     <= (idx_q == XW'(NUM_DIGITS - 1)) ? '0 : idx_q + XW'(1);
      end else begin
        refresh_q <= refresh_q + RW'(1);
      end
      out7   <= seg_next;
      dp_out <= dp_next;
      en_out <= en_next;

      case (state)
        IDLE: begin
          if (load) begin
            if (mode) begin
              bin_q     <= data_in;
              bcd_q     <= '0;
              dp_pend_q <= dp_in;
              ovf_acc_q <= 1'b0;
              iter_q    <= '0;
              state     <= CONV;
            end else begin
              disp_q <= data_in;
              dp_q   <= dp_in;
              ovf    <= 1'b0;
            end
          end
        end
        CONV: begin
          // Display, dp and ovf change together on the last step only.
          if (iter_q == IW'(W - 1)) begin
            disp_q <= bcd_next;
            dp_q   <= dp_pend_q;
            ovf    <= ovf_acc_q | carry;
            state  <= IDLE;
          end else begin
            bcd_q     <= bcd_next;
            bin_q     <= bin_next;
            ovf_acc_q <= ovf_acc_q | carry;
            iter_q    <= iter_q + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg7_display_mux.md
SEG7_DISPLAY_MUX -- requirements
Module: seg7_display_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 8, meaning: number of multiplexed digits; legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 100000, meaning: clocks each digit stays enabled; legal minimum 2.
REQ-003 Parameter W (derived, not overridable): 4*NUM_DIGITS, the data width.
REQ-004 Port Clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port Reset  input  1  asynchronous, active-high reset.
REQ-006 Port load  input  1  request to capture data_in, mode and dp_in; one-cycle strobe.
REQ-007 Port data_in  input  W  value to display: nibbles in hex mode, unsigned binary in decimal mode.
REQ-008 Port mode  input  1  0 = hex, 1 = decimal (binary-to-BCD conversion).
REQ-009 Port blank_lz  input  1  1 = blank leading zero digits; sampled live, not latched.
REQ-010 Port dp_in  input  NUM_DIGITS  decimal-point request per digit.
REQ-011 Port busy  output  1  high while a decimal conversion is in progress.
REQ-012 Port ovf  output  1  last accepted decimal value was >= 10^NUM_DIGITS.
REQ-013 Port out7  output  7  segment drive, active-low, bit0 = a through bit6 = g.
REQ-014 Port dp_out  output  1  decimal-point drive, active-low.
REQ-015 Port en_out  output  NUM_DIGITS  digit enables, active-low, at most one low.

Function
REQ-016 A load SHALL be accepted when load=1 and busy=0; when busy=1 it SHALL be ignored with no side effect.
REQ-017 Hex mode accept SHALL write data_in and dp_in into the display register at the accepting edge, clear ovf, and leave busy=0.
REQ-018 Decimal mode accept SHALL latch data_in and dp_in and enter state CONV, with busy=1 from the next cycle.
REQ-019 The converter FSM SHALL have states IDLE and CONV; CONV SHALL run exactly W shift-and-add-3 (double-dabble) iterations, then return to IDLE.
REQ-020 The BCD register SHALL be W bits wide; bits shifted out of the top digit SHALL set ovf, so the result equals value mod 10^NUM_DIGITS.
REQ-021 The display register and ovf SHALL update atomically at the W-th edge after the accepting edge, and busy SHALL be 0 in the following cycle.
REQ-022 During CONV the display SHALL continue to show the previous display register contents, with no partial values.
REQ-023 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, the digit index SHALL advance and wrap from NUM_DIGITS-1 to 0.
REQ-024 Outputs SHALL be registered: out7, dp_out and en_out reflect the digit index of the previous cycle (1-cycle latency).
REQ-025 en_out SHALL drive bit[idx] low and all other bits high.
REQ-026 Hex decode 0..F SHALL be standard active-low: 0 = 7'h40, 1 = 7'h79, 4 = 7'h19, 5 = 7'h12, 8 = 7'h00, F = 7'h0E.
REQ-027 With blank_lz=1, a digit SHALL be blanked (out7 = 7'h7F, dp_out = 1) when it and every higher digit are zero.
REQ-028 Digit 0 SHALL never be blanked.
REQ-029 A digit with its dp bit set SHALL NOT be blanked.
REQ-030 dp_out SHALL be the inverse of the latched dp bit for the active digit.

Reset
REQ-031 Reset=1 SHALL immediately and asynchronously force: FSM IDLE, busy=0, ovf=0, display and dp registers 0, refresh counter 0, digit index 0, en_out all ones, out7 = 7'h7F, dp_out = 1.
REQ-032 Reset asserted during CONV SHALL abort the conversion with no display update.
REQ-033 In the first cycle after Reset is released, digit 0 SHALL be enabled, showing 7'h40.

Verification
REQ-034 NUM_DIGITS=4, REFRESH_DIV=4, hex load 16'h1234 -> en_out cycles 1110, 1101, 1011, 0111, each for 4 clocks; out7 shows digit patterns 4, 3, 2, 1.
REQ-035 NUM_DIGITS=4, decimal load 16'h04D2 -> busy=1 for 16 cycles; the display reads 1234 (digit0 = 7'h19); ovf=0.
REQ-036 NUM_DIGITS=8, decimal load 32'hFFFFFFFF -> after 32 cycles the display reads 94967295 and ovf=1.
REQ-037 NUM_DIGITS=4, hex 16'h0050, blank_lz=1 -> digits 3 and 2 show 7'h7F, digit1 shows 7'h12, digit0 shows 7'h40; setting dp_in[3]=1 unblanks digit 3 with dp_out=0.
REQ-038 A second load during busy -> ignored, and the first result is displayed; Reset pulsed mid-CONV -> busy=0, display 0, no later update.
